fsb_ctrl: RTL and testbench



---
 rtl/fsb_ctrl_pkg.sv | 9 +
 rtl/fsb_ctrl_if.sv | 23 ++
 rtl/fsb_ctrl.sv | 65 ++++++
 tb/tb_fsb_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/fsb_ctrl_pkg.sv
// Shared constants for the front-side-bus cycle tracker.
// Output vector order everywhere is {ndtack, nvpa, ainact, bact, cact}.
package fsb_ctrl_pkg;
  localparam logic RST_NDTACK = 1'b1;
  localparam logic RST_NVPA   = 1'b1;
  localparam logic RST_AINACT = 1'b1;
  localparam logic RST_BACT   = 1'b0;
  localparam logic RST_CACT   = 1'b0;
endpackage

// File: rtl/fsb_ctrl_if.sv
// 68000 front-side-bus signals seen by the cycle tracker.
// Handshake: a cycle is open while nAS is sampled low; the tracker answers with
// nDTACK (or nVPA when IACS=1) once Ready=1, holding it until nAS is sampled high.
interface fsb_ctrl_if;
  logic nAS;
  logic Ready;
  logic IACS;
  logic nDTACK;
  logic nVPA;
  logic AINACT;
  logic BACT;
  logic CACT;

  modport master (
    output nAS, Ready, IACS,
    input  nDTACK, nVPA, AINACT, BACT, CACT
  );

  modport slave (
    input  nAS, Ready, IACS,
    output nDTACK, nVPA, AINACT, BACT, CACT
  );
endinterface

// File: rtl/fsb_ctrl.sv
// Bus cycle tracker and acknowledge generator clocked by FCLK.
// The five registered outputs are the whole state; BACT/CACT double as the phase debug view.
module fsb_ctrl
  import fsb_ctrl_pkg::*;
(
  input  logic        FCLK,
  input  logic        Reset,
  fsb_ctrl_if.slave   bus
);

  logic ndtack_q, nvpa_q, ainact_q, bact_q, cact_q;
  logic ndtack_d, nvpa_d, ainact_d, bact_d, cact_d;
  logic as_s;

  assign as_s = ~bus.nAS;

  always_ff @(posedge FCLK) begin
    if (Reset) begin
      ndtack_q <= RST_NDTACK;
      nvpa_q   <= RST_NVPA;
      ainact_q <= RST_AINACT;
      bact_q   <= RST_BACT;
      cact_q   <= RST_CACT;
    end else begin
      ndtack_q <= ndtack_d;
      nvpa_q   <= nvpa_d;
      ainact_q <= ainact_d;
      bact_q   <= bact_d;
      cact_q   <= cact_d;
    end
  end

  always_comb begin
    ndtack_d = 1'b1;
    nvpa_d   = 1'b1;
    ainact_d = 1'b1;
    bact_d   = 1'b0;
    cact_d   = 1'b0;
    if (as_s == 1'b1) begin
      ainact_d = 1'b0;
      bact_d   = 1'b1;
      if (bact_q) begin
        cact_d   = 1'b1;
        ndtack_d = ndtack_q;
        nvpa_d   = nvpa_q;
        // Only the first Ready decides which acknowledge fires; it then latches.
        if (ndtack_q && nvpa_q && Ready_s()) begin
          if (bus.IACS) nvpa_d   = 1'b0;
          else          ndtack_d = 1'b0;
        end
      end
    end
  end

  function automatic logic Ready_s();
    return bus.Ready;
  endfunction

  assign bus.nDTACK = ndtack_q;
  assign bus.nVPA   = nvpa_q;
  assign bus.AINACT = ainact_q;
  assign bus.BACT   = bact_q;
  assign bus.CACT   = cact_q;

endmodule

// File: tb/tb_fsb_ctrl.sv
// Directed bench for fsb_ctrl: driver pushes the expected post-edge outputs,
// a monitor pops and compares them one step after every rising edge.
module tb_fsb_ctrl;
  import fsb_ctrl_pkg::*;

  // {nDTACK, nVPA, AINACT, BACT, CACT}
  localparam logic [4:0] E_IDLE = 5'b11100;
  localparam logic [4:0] E_B1   = 5'b11010;
  localparam logic [4:0] E_WAIT = 5'b11011;
  localparam logic [4:0] E_DTK  = 5'b01011;
  localparam logic [4:0] E_VPA  = 5'b10011;

  logic FCLK;
  logic Reset;
  fsb_ctrl_if bus ();

  int checks   = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  fsb_ctrl dut (
    .FCLK  (FCLK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial FCLK = 1'b0;
  always #25 FCLK = ~FCLK;

  // driver: apply inputs mid-low-phase, record what the next edge must produce
  task automatic step(input logic rst, input logic nas, input logic rdy,
                      input logic iacs, input logic [4:0] exp, input logic x_mid);
    @(negedge FCLK);
    Reset     = rst;
    bus.nAS   = nas;
    bus.Ready = rdy;
    bus.IACS  = iacs;
    exp_q.push_back(exp);
    @(posedge FCLK);
    if (x_mid) begin
      #10 bus.nAS = 1'bx;
    end
  endtask

  // monitor / scoreboard
  always @(posedge FCLK) begin
    logic [4:0] act;
    logic [4:0] exp;
    #1;
    act = {bus.nDTACK, bus.nVPA, bus.AINACT, bus.BACT, bus.CACT};
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL outputs @%0t: got %b expected %b", $time, act, exp);
      end
      checks++;
      if (bus.AINACT !== ~bus.BACT || (bus.CACT && !bus.BACT) || (!bus.nDTACK && !bus.nVPA)) begin
        failures++;
        $display("FAIL invariant @%0t: got %b expected consistent flags", $time, act);
      end
    end
  end

  initial begin
    Reset = 1'b1; bus.nAS = 1'b0; bus.Ready = 1'b1; bus.IACS = 1'b0;
    // reset held with strobe asserted
    step(1, 0, 1, 0, E_IDLE, 0);
    step(1, 0, 1, 0, E_IDLE, 0);
    step(0, 1, 1, 0, E_IDLE, 0);
    // normal cycle, Ready=1
    step(0, 0, 1, 0, E_B1,  1);
    step(0, 0, 1, 0, E_DTK, 1);
    step(0, 0, 1, 0, E_DTK, 0);
    step(0, 1, 1, 0, E_IDLE, 0);
    // wait states then Ready, later Ready drop ignored
    step(0, 0, 0, 0, E_B1,  0);
    step(0, 0, 0, 0, E_WAIT, 0);
    step(0, 0, 0, 0, E_WAIT, 0);
    step(0, 0, 1, 0, E_DTK, 0);
    step(0, 0, 0, 0, E_DTK, 0);
    step(0, 1, 0, 0, E_IDLE, 0);
    // interrupt acknowledge, later IACS change ignored
    step(0, 0, 1, 1, E_B1,  0);
    step(0, 0, 1, 1, E_VPA, 0);
    step(0, 0, 1, 0, E_VPA, 0);
    step(0, 1, 1, 0, E_IDLE, 0);
    // back-to-back cycles with one idle edge
    step(0, 0, 1, 0, E_B1,  0);
    step(0, 0, 1, 0, E_DTK, 0);
    step(0, 1, 1, 0, E_IDLE, 0);
    step(0, 0, 1, 0, E_B1,  0);
    step(0, 0, 1, 0, E_DTK, 0);
    step(0, 1, 1, 0, E_IDLE, 0);
    // aborted cycle, no acknowledge
    step(0, 0, 0, 0, E_B1,  1);
    step(0, 1, 1, 0, E_IDLE, 0);
    step(0, 1, 1, 0, E_IDLE, 0);
    // reset wins mid-cycle
    step(0, 0, 1, 0, E_B1,  0);
    step(0, 0, 1, 0, E_DTK, 0);
    step(1, 0, 1, 0, E_IDLE, 0);
    step(0, 0, 1, 0, E_B1,  0);
    step(0, 1, 1, 0, E_IDLE, 0);

    @(negedge FCLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
